// File: rtl/vlw_wb_collector_pkg.sv
// Shared types and constants for the vector load write-back collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vlw_wb_collector_pkg;

    localparam int LANES    = 8;
    localparam int VLEN_MAX = 8;

    // Vector load/store opcodes, shared with the decode-stage controller
    localparam logic [6:0] LW_V = 7'b0000111;
    localparam logic [6:0] SW_V = 7'b0100111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Effective element count: the vlen register clamped to the lane count
    function automatic logic [3:0] clamp_vlen(input logic [31:0] vlen);
        return (vlen >= 32'(VLEN_MAX)) ? 4'(VLEN_MAX) : vlen[3:0];
    endfunction

endpackage

// File: rtl/vlw_wb_collector_popcount8.sv
// Counts set bits of an 8-bit lane mask.
// Latency: combinational.
// Backpressure: none.
module popcount8
    import vlw_wb_collector_pkg::*;
(
    input  logic [7:0] mask,
    output logic [3:0] count
);

    // Sum the mask bits
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            count = count + {3'b000, mask[i]};
        end
    end

endmodule

// File: rtl/vlw_wb_collector.sv
// Collects vector-load element returns into 8 lanes, commits one vector register write; forwards scalar write-backs.
// Latency: last element -> vector write 1 cycle; scalar accept -> write 1 cycle (2 if it lands on a vector write).
// Backpressure: s_ready drops only during the COMMIT cycle; element returns are never stalled.
module vlw_wb_collector #(
    parameter int DATA_W = 32,
    parameter int LANES  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_rd,
    input  logic [31:0]       start_vlen,
    input  logic              elem_valid,
    input  logic [2:0]        elem_idx,
    input  logic [DATA_W-1:0] elem_data,
    input  logic              s_regwrite,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              WB_RegWrite,
    output logic              WB_VRegWrite,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] write_data_v0,
    output logic [DATA_W-1:0] write_data_v1,
    output logic [DATA_W-1:0] write_data_v2,
    output logic [DATA_W-1:0] write_data_v3,
    output logic [DATA_W-1:0] write_data_v4,
    output logic [DATA_W-1:0] write_data_v5,
    output logic [DATA_W-1:0] write_data_v6,
    output logic [DATA_W-1:0] write_data_v7,
    output logic              busy,
    output logic              err
);

    import vlw_wb_collector_pkg::*;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] rd_q;
    logic [3:0]        eff_len_q;
    logic [DATA_W-1:0] buf_q [LANES];
    logic [LANES-1:0]  mask_q;
    logic [DATA_W-1:0] v_q [LANES];

    // Scalar write that was accepted on the cycle a vector commit was decided;
    // it goes out the cycle after COMMIT, a slot no new scalar can claim
    // because s_ready is low during COMMIT.
    logic              sc_pend_vld;
    logic [ADDR_W-1:0] sc_pend_addr;
    logic [DATA_W-1:0] sc_pend_data;

    logic [3:0]        start_eff;
    logic              load_go;
    logic              beat_ok;
    logic [LANES-1:0]  mask_beat;
    logic [3:0]        cnt_beat;
    logic              s_acc;

    logic              vwr_nxt;
    logic              busy_nxt;
    logic              sready_nxt;
    logic              err_nxt;
    logic              sc_emit;
    logic [ADDR_W-1:0] sc_emit_addr;
    logic [DATA_W-1:0] sc_emit_data;
    logic              pend_set;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] lane_nxt [LANES];

    assign start_eff = clamp_vlen(start_vlen);
    assign load_go   = (state == ST_IDLE) && start && (start_eff != 4'd0);
    assign beat_ok   = (state == ST_COLLECT) && elem_valid && ({1'b0, elem_idx} < eff_len_q);
    assign mask_beat = mask_q | (beat_ok ? ({{(LANES-1){1'b0}}, 1'b1} << elem_idx) : '0);
    assign s_acc     = s_regwrite && s_ready;

    popcount8 u_popcount8 (
        .mask  (mask_beat),
        .count (cnt_beat)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: commit once every lane below eff_len has arrived
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (load_go) state_nxt = ST_COLLECT;
            ST_COLLECT: if (beat_ok && (cnt_beat == eff_len_q)) state_nxt = ST_COMMIT;
            ST_COMMIT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output next-values; every port is registered from these
    always_comb begin
        vwr_nxt    = (state_nxt == ST_COMMIT);
        busy_nxt   = (state_nxt != ST_IDLE);
        sready_nxt = (state_nxt != ST_COMMIT);
        err_nxt    = err
                   | (start && (state != ST_IDLE))
                   | (elem_valid && (state != ST_COLLECT))
                   | (elem_valid && (state == ST_COLLECT) && ({1'b0, elem_idx} >= eff_len_q));

        // Lanes at or above eff_len read as zero; the completing beat bypasses the buffer
        for (int i = 0; i < LANES; i++) begin
            lane_nxt[i] = '0;
            if (vwr_nxt && (4'(i) < eff_len_q)) begin
                lane_nxt[i] = (beat_ok && (elem_idx == 3'(i))) ? elem_data : buf_q[i];
            end
        end

        sc_emit      = 1'b0;
        sc_emit_addr = '0;
        sc_emit_data = '0;
        pend_set     = 1'b0;
        if (vwr_nxt) begin
            pend_set = s_acc;
        end else if (sc_pend_vld) begin
            sc_emit      = 1'b1;
            sc_emit_addr = sc_pend_addr;
            sc_emit_data = sc_pend_data;
        end else if (s_acc) begin
            sc_emit      = 1'b1;
            sc_emit_addr = s_addr;
            sc_emit_data = s_data;
        end

        addr_nxt = vwr_nxt ? rd_q : sc_emit_addr;
    end

    // Load context and lane buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q      <= '0;
            eff_len_q <= '0;
            mask_q    <= '0;
            for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
        end else if (load_go) begin
            rd_q      <= start_rd;
            eff_len_q <= start_eff;
            mask_q    <= '0;
            for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
        end else if (beat_ok) begin
            buf_q[elem_idx] <= elem_data;
            mask_q          <= mask_beat;
        end
    end

    // Registered outputs and the deferred scalar slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WB_VRegWrite <= 1'b0;
            WB_RegWrite  <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            s_ready      <= 1'b0;
            sc_pend_vld  <= 1'b0;
            sc_pend_addr <= '0;
            sc_pend_data <= '0;
            for (int i = 0; i < LANES; i++) v_q[i] <= '0;
        end else begin
            WB_VRegWrite <= vwr_nxt;
            WB_RegWrite  <= sc_emit;
            write_addr   <= addr_nxt;
            write_data   <= sc_emit_data;
            busy         <= busy_nxt;
            err          <= err_nxt;
            s_ready      <= sready_nxt;
            sc_pend_vld  <= pend_set;
            if (pend_set) begin
                sc_pend_addr <= s_addr;
                sc_pend_data <= s_data;
            end
            for (int i = 0; i < LANES; i++) v_q[i] <= lane_nxt[i];
        end
    end

    assign write_data_v0 = v_q[0];
    assign write_data_v1 = v_q[1];
    assign write_data_v2 = v_q[2];
    assign write_data_v3 = v_q[3];
    assign write_data_v4 = v_q[4];
    assign write_data_v5 = v_q[5];
    assign write_data_v6 = v_q[6];
    assign write_data_v7 = v_q[7];

endmodule

// File: tb/tb_vlw_wb_collector.sv
// Randomized + directed bench for vlw_wb_collector against a transaction-level model.
// Latency: n/a.
// Backpressure: scalar source holds its request until accepted.
module tb_vlw_wb_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  start_rd;
    logic [31:0] start_vlen;
    logic        elem_valid;
    logic [2:0]  elem_idx;
    logic [31:0] elem_data;
    logic        s_regwrite;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        s_ready;
    logic        WB_RegWrite;
    logic        WB_VRegWrite;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] write_data_v0, write_data_v1, write_data_v2, write_data_v3;
    logic [31:0] write_data_v4, write_data_v5, write_data_v6, write_data_v7;
    logic        busy;
    logic        err;

    logic [31:0] dut_v [8];
    assign dut_v[0] = write_data_v0;
    assign dut_v[1] = write_data_v1;
    assign dut_v[2] = write_data_v2;
    assign dut_v[3] = write_data_v3;
    assign dut_v[4] = write_data_v4;
    assign dut_v[5] = write_data_v5;
    assign dut_v[6] = write_data_v6;
    assign dut_v[7] = write_data_v7;

    vlw_wb_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_rd      (start_rd),
        .start_vlen    (start_vlen),
        .elem_valid    (elem_valid),
        .elem_idx      (elem_idx),
        .elem_data     (elem_data),
        .s_regwrite    (s_regwrite),
        .s_addr        (s_addr),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .WB_RegWrite   (WB_RegWrite),
        .WB_VRegWrite  (WB_VRegWrite),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_data_v0 (write_data_v0),
        .write_data_v1 (write_data_v1),
        .write_data_v2 (write_data_v2),
        .write_data_v3 (write_data_v3),
        .write_data_v4 (write_data_v4),
        .write_data_v5 (write_data_v5),
        .write_data_v6 (write_data_v6),
        .write_data_v7 (write_data_v7),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A load is "open" while elements are being gathered; the cycle after the
    // last distinct in-range index arrives is the commit cycle. Scalar writes
    // go through a FIFO that is drained one per cycle except on a vector write.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } sw_t;

    int          m_phase;      // 0 idle, 1 gathering, 2 commit cycle
    logic [4:0]  m_rd;
    int          m_len;
    logic [31:0] m_lane [8];
    bit          m_seen [8];
    bit          m_err;
    bit          m_acc;
    sw_t         m_swq [$];

    bit          e_vwr, e_wr, e_busy, e_err, e_srdy;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_v [8];

    initial begin
        m_phase = 0; m_err = 0; m_acc = 0; m_len = 0; m_rd = '0;
        e_vwr = 0; e_wr = 0; e_busy = 0; e_err = 0; e_srdy = 0;
        e_addr = '0; e_data = '0;
        foreach (e_v[i]) e_v[i] = '0;
        foreach (m_lane[i]) begin m_lane[i] = '0; m_seen[i] = 0; end
    end

    task automatic model_step();
        bit  done;
        int  got;
        sw_t w;
        done  = 0;
        m_acc = 0;
        e_vwr = 0; e_wr = 0; e_addr = '0; e_data = '0;
        foreach (e_v[i]) e_v[i] = '0;
        if (!rst_n) begin
            m_phase = 0; m_err = 0; m_swq.delete();
            e_busy = 0; e_err = 0; e_srdy = 0;
            return;
        end
        m_acc = s_regwrite && e_srdy;
        if (start && m_phase != 0) m_err = 1;
        if (elem_valid && m_phase != 1) m_err = 1;
        case (m_phase)
            0: if (start) begin
                m_len = (start_vlen > 32'd8) ? 8 : int'(start_vlen);
                if (m_len > 0) begin
                    m_phase = 1;
                    m_rd    = start_rd;
                    foreach (m_lane[i]) begin m_lane[i] = '0; m_seen[i] = 0; end
                end
            end
            1: if (elem_valid) begin
                if (int'(elem_idx) < m_len) begin
                    m_lane[elem_idx] = elem_data;
                    m_seen[elem_idx] = 1;
                    got = 0;
                    foreach (m_seen[i]) got += int'(m_seen[i]);
                    if (got == m_len) done = 1;
                end else begin
                    m_err = 1;
                end
            end
            default: m_phase = 0;
        endcase
        if (done) begin
            m_phase = 2;
            e_vwr   = 1;
            e_addr  = m_rd;
            foreach (e_v[i]) e_v[i] = m_lane[i];
        end
        if (m_acc) begin
            w.a = s_addr;
            w.d = s_data;
            m_swq.push_back(w);
        end
        if (!done && m_swq.size() > 0) begin
            w      = m_swq.pop_front();
            e_wr   = 1;
            e_addr = w.a;
            e_data = w.d;
        end
        e_busy = (m_phase != 0);
        e_err  = m_err;
        e_srdy = (m_phase != 2);
    endtask

    task automatic check_outputs();
        chk("WB_VRegWrite", 32'(WB_VRegWrite), 32'(e_vwr));
        chk("WB_RegWrite", 32'(WB_RegWrite), 32'(e_wr));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("err", 32'(err), 32'(e_err));
        chk("s_ready", 32'(s_ready), 32'(e_srdy));
        chk("strobe_overlap", 32'(WB_VRegWrite & WB_RegWrite), 32'd0);
        if (e_vwr || e_wr || !rst_n) chk("write_addr", 32'(write_addr), 32'(e_addr));
        if (e_wr || !rst_n) chk("write_data", write_data, e_data);
        if (e_vwr || !rst_n) begin
            for (int i = 0; i < 8; i++) chk($sformatf("write_data_v%0d", i), dut_v[i], e_v[i]);
        end
    endtask

    // One clock: model sees the inputs at the edge, outputs are checked at the
    // following falling edge, then one-shot inputs are dropped.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        start      = 1'b0;
        elem_valid = 1'b0;
        if (m_acc) s_regwrite = 1'b0;
    endtask

    task automatic do_idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [4:0] rd, input logic [31:0] vlen);
        start = 1'b1; start_rd = rd; start_vlen = vlen;
        tick();
    endtask

    task automatic do_elem(input logic [2:0] idx, input logic [31:0] d);
        elem_valid = 1'b1; elem_idx = idx; elem_data = d;
        tick();
    endtask

    task automatic scalar_req(input logic [4:0] a, input logic [31:0] d);
        s_regwrite = 1'b1; s_addr = a; s_data = d;
    endtask

    int ord [8] = '{3, 0, 5, 7, 1, 6, 2, 4};

    initial begin
        int r;
        rst_n = 1'b0; start = 1'b0; start_rd = '0; start_vlen = '0;
        elem_valid = 1'b0; elem_idx = '0; elem_data = '0;
        s_regwrite = 1'b0; s_addr = '0; s_data = '0;

        @(negedge clk);
        do_idle(3);
        rst_n = 1'b1;
        do_idle(2);

        // Full-length load, indices counting down
        do_start(5'd3, 32'd8);
        for (int i = 7; i >= 0; i--) do_elem(3'(i), 32'(i * 16));
        do_idle(2);

        // Short load, then a clamped load with scrambled arrival order
        do_start(5'd9, 32'd3);
        do_elem(3'd2, 32'hA); do_elem(3'd1, 32'hB); do_elem(3'd0, 32'hC);
        do_idle(1);
        do_start(5'd1, 32'd20);
        for (int i = 0; i < 8; i++) do_elem(3'(ord[i]), 32'h100 + 32'(ord[i]));
        do_idle(2);

        // Scalar during collection, and a scalar raised in the commit cycle
        do_start(5'd6, 32'd2);
        scalar_req(5'd4, 32'hDEAD);
        do_elem(3'd1, 32'h1);
        do_elem(3'd0, 32'h2);
        scalar_req(5'd7, 32'hBEEF);
        do_idle(4);

        // Scalar accepted on the completing beat
        do_start(5'd2, 32'd1);
        scalar_req(5'd5, 32'h55);
        do_elem(3'd0, 32'h99);
        do_idle(3);

        // Zero-length load is a no-op
        do_start(5'd8, 32'd0);
        do_idle(2);

        // Reset in the middle of a load, then a fresh single-lane load
        do_start(5'd10, 32'd4);
        do_elem(3'd3, 32'h33); do_elem(3'd2, 32'h22);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        do_idle(1);
        do_start(5'd11, 32'd1);
        do_elem(3'd0, 32'h77);
        do_idle(2);

        // Duplicate and out-of-range indices
        do_start(5'd12, 32'd4);
        do_elem(3'd3, 32'h11); do_elem(3'd3, 32'h22); do_elem(3'd2, 32'h33);
        do_elem(3'd5, 32'h55); do_elem(3'd1, 32'h44); do_elem(3'd0, 32'h66);
        do_idle(2);

        // Start while busy, and start in the commit cycle
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        do_start(5'd13, 32'd2);
        do_start(5'd14, 32'd5);
        do_elem(3'd0, 32'h1); do_elem(3'd1, 32'h2);
        do_start(5'd15, 32'd3);
        do_idle(3);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            if ((m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0)) begin
                start    = 1'b1;
                start_rd = 5'($urandom);
                r        = $urandom_range(0, 11);
                start_vlen = (r == 11) ? $urandom : 32'(r);
            end
            if ((m_phase == 1) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0)) begin
                elem_valid = 1'b1;
                elem_idx   = (m_phase == 1 && $urandom_range(0, 9) != 0)
                           ? 3'($urandom_range(0, m_len - 1)) : 3'($urandom);
                elem_data  = $urandom;
            end
            if (!s_regwrite && $urandom_range(0, 2) == 0) scalar_req(5'($urandom), $urandom);
            tick();
        end
        rst_n = 1'b1;
        do_idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
